// File: rtl/psram_pkg.sv
// Shared types and default timing for the asynchronous PSRAM controller.
// Defaults assume a 100 MHz sysclk and a 70 ns part.
package psram_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READ,
        ST_PAGE,
        ST_WRITE,
        ST_RECOVER
    } state_t;

    localparam int CLK_PERIOD_NS = 10;

    // One cycle of margin on top of the 70 ns access time.
    localparam int DEF_T_RD  = 8;
    localparam int DEF_T_PG  = 3;
    localparam int DEF_T_WR  = 8;
    localparam int DEF_T_REC = 2;

    function automatic int max4(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage

// File: rtl/psram_dq_io.sv
// Data-pin slice: write data register, output enable and read capture register,
// kept together so all three can be packed into the I/O cells.
module psram_dq_io
    import psram_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic              sysclk,
    input  logic              rst,
    input  logic              i_load,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic              i_oe_next,
    input  logic              i_capture,
    output logic [DATA_W-1:0] o_rdata,
    inout  wire  [DATA_W-1:0] io_dq
);

    logic              r_oe;
    logic [DATA_W-1:0] r_dout;
    logic [DATA_W-1:0] r_din;

    always_ff @(posedge sysclk) begin
        if (rst) begin
            r_oe   <= 1'b0;
            r_dout <= '0;
            r_din  <= '0;
        end else begin
            r_oe <= i_oe_next;
            if (i_load)
                r_dout <= i_wdata;
            if (i_capture)
                r_din <= io_dq;
        end
    end

    assign io_dq   = r_oe ? r_dout : {DATA_W{1'bz}};
    assign o_rdata = r_din;

endmodule

// File: rtl/psram_async_ctrl.sv
// Asynchronous PSRAM controller: valid/ready requests, single writes and
// page-mode burst reads that wrap inside a 16-word page.
module psram_async_ctrl
    import psram_pkg::*;
#(
    parameter int ADDR_W = 26,
    parameter int DATA_W = 16,
    parameter int T_RD   = DEF_T_RD,
    parameter int T_PG   = DEF_T_PG,
    parameter int T_WR   = DEF_T_WR,
    parameter int T_REC  = DEF_T_REC
) (
    input  logic                  sysclk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [ADDR_W-1:0]     req_addr,
    input  logic [DATA_W/8-1:0]   req_be,
    input  logic [DATA_W-1:0]     req_wdata,
    input  logic [3:0]            req_len,
    output logic                  rd_valid,
    output logic [DATA_W-1:0]     rd_data,
    output logic                  rd_last,
    output logic [ADDR_W-1:0]     MEM_ADDR,
    output logic                  MEM_CEN,
    output logic                  MEM_OEN,
    output logic                  MEM_WEN,
    output logic [DATA_W/8-1:0]   MEM_BEN,
    output logic                  MEM_ADV,
    inout  wire  [DATA_W-1:0]     MEM_DQ
);

    localparam int BE_W  = DATA_W / 8;
    localparam int T_MAX = max4(T_RD, T_PG, T_WR, T_REC);
    // The counter is loaded with T-1, so it never has to hold T_MAX itself.
    localparam int CNT_W = (T_MAX > 1) ? $clog2(T_MAX) : 1;

    localparam logic [CNT_W-1:0] LD_RD  = CNT_W'(T_RD - 1);
    localparam logic [CNT_W-1:0] LD_PG  = CNT_W'(T_PG - 1);
    localparam logic [CNT_W-1:0] LD_WR  = CNT_W'(T_WR - 1);
    localparam logic [CNT_W-1:0] LD_REC = CNT_W'(T_REC - 1);

    state_t            r_state;
    logic [CNT_W-1:0]  r_wait;
    logic [3:0]        r_len;
    logic [ADDR_W-1:0] r_addr;
    logic              r_req_ready;
    logic              r_rd_valid;
    logic              r_rd_last;
    logic              r_cen;
    logic              r_oen;
    logic              r_wen;
    logic [BE_W-1:0]   r_ben;

    logic w_accept;
    logic w_wait_done;
    logic w_capture;
    logic w_load;
    logic w_oe_next;

    assign w_accept    = req_valid && r_req_ready;
    assign w_wait_done = (r_wait == '0);
    assign w_capture   = !rst && ((r_state == ST_READ) || (r_state == ST_PAGE)) && w_wait_done;
    assign w_load      = !rst && w_accept && req_write;
    // Drive from the first WEN-low cycle through the first recovery cycle for data hold.
    assign w_oe_next   = !rst && ((w_accept && req_write) || (r_state == ST_WRITE));

    always_ff @(posedge sysclk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_wait      <= '0;
            r_len       <= '0;
            r_addr      <= '0;
            r_req_ready <= 1'b0;
            r_rd_valid  <= 1'b0;
            r_rd_last   <= 1'b0;
            r_cen       <= 1'b1;
            r_oen       <= 1'b1;
            r_wen       <= 1'b1;
            r_ben       <= '1;
        end else begin
            r_rd_valid <= 1'b0;
            r_rd_last  <= 1'b0;
            unique case (r_state)
                ST_IDLE: begin
                    r_req_ready <= 1'b1;
                    if (w_accept) begin
                        r_req_ready <= 1'b0;
                        r_addr      <= req_addr;
                        r_ben       <= ~req_be;
                        r_cen       <= 1'b0;
                        if (req_write) begin
                            r_len   <= '0;
                            r_wen   <= 1'b0;
                            r_wait  <= LD_WR;
                            r_state <= ST_WRITE;
                        end else begin
                            r_len   <= req_len;
                            r_oen   <= 1'b0;
                            r_wait  <= LD_RD;
                            r_state <= ST_READ;
                        end
                    end
                end

                ST_READ, ST_PAGE: begin
                    if (w_wait_done) begin
                        r_rd_valid <= 1'b1;
                        r_rd_last  <= (r_len == 4'd0);
                        if (r_len == 4'd0) begin
                            r_cen   <= 1'b1;
                            r_oen   <= 1'b1;
                            r_ben   <= '1;
                            r_wait  <= LD_REC;
                            r_state <= ST_RECOVER;
                        end else begin
                            // Only the low nibble advances, so the burst wraps in its page.
                            r_len        <= r_len - 4'd1;
                            r_addr[3:0]  <= r_addr[3:0] + 4'd1;
                            r_wait       <= LD_PG;
                            r_state      <= ST_PAGE;
                        end
                    end else begin
                        r_wait <= r_wait - 1'b1;
                    end
                end

                ST_WRITE: begin
                    if (w_wait_done) begin
                        r_cen   <= 1'b1;
                        r_wen   <= 1'b1;
                        r_ben   <= '1;
                        r_wait  <= LD_REC;
                        r_state <= ST_RECOVER;
                    end else begin
                        r_wait <= r_wait - 1'b1;
                    end
                end

                ST_RECOVER: begin
                    if (w_wait_done) begin
                        r_req_ready <= 1'b1;
                        r_state     <= ST_IDLE;
                    end else begin
                        r_wait <= r_wait - 1'b1;
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    psram_dq_io #(
        .DATA_W (DATA_W)
    ) u_dq_io (
        .sysclk    (sysclk),
        .rst       (rst),
        .i_load    (w_load),
        .i_wdata   (req_wdata),
        .i_oe_next (w_oe_next),
        .i_capture (w_capture),
        .o_rdata   (rd_data),
        .io_dq     (MEM_DQ)
    );

    assign req_ready = r_req_ready;
    assign rd_valid  = r_rd_valid;
    assign rd_last   = r_rd_last;
    assign MEM_ADDR  = r_addr;
    assign MEM_CEN   = r_cen;
    assign MEM_OEN   = r_oen;
    assign MEM_WEN   = r_wen;
    assign MEM_BEN   = r_ben;
    assign MEM_ADV   = 1'b0;

endmodule
